// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, converter FSM states, glyph table.
// Leading-zero blanking in decimal mode is enabled by defining LEADING_ZERO_BLANK_EN.
package seg_pkg;

    localparam int DIGITS = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here and applied by the scanner.
    function automatic logic [7:0] glyph(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// One conversion takes LOAD + 32 x SHIFT + LATCH = 34 cycles; done is high during LATCH.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        done
);
    import seg_pkg::*;

    conv_state_t state;
    logic [4:0]  cnt;
    logic [39:0] bcd_r;
    logic [31:0] bin_r;
    logic [39:0] bcd_adj;

    function automatic logic [39:0] add3(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int i = 0; i < 10; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb bcd_adj = add3(bcd_r);

    // bin is captured only in LOAD, so input changes mid-conversion are ignored.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= LOAD;
            cnt   <= 5'd0;
            bcd_r <= 40'd0;
            bin_r <= 32'd0;
        end else begin
            case (state)
                LOAD: begin
                    bin_r <= bin;
                    bcd_r <= 40'd0;
                    cnt   <= 5'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj[38:0], bin_r, 1'b0};
                    cnt            <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= LATCH;
                end
                LATCH:   state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign done = (state == LATCH);

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver showing data in hex or decimal.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in decimal mode.
module seg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mod,
    input  logic [31:0] data,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);
    import seg_pkg::*;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    logic          mod_q;
    logic [31:0]   hex_q;
    logic [31:0]   dec_q;
    logic          ovf_q;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic          wrap;
    logic [39:0]   bcd;
    logic          done;
    logic [31:0]   disp;
    logic [31:0]   disp_sh;
    logic [7:0]    seg_next;
    logic [7:0]    an_q;
    logic [7:0]    seg_q;

    bin2bcd_seq u_conv (
        .clk  (clk),
        .clr  (clr),
        .bin  (data),
        .bcd  (bcd),
        .done (done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mod_q <= 1'b1;
            hex_q <= 32'd0;
            dec_q <= 32'd0;
            ovf_q <= 1'b0;
        end else begin
            mod_q <= mod;
            hex_q <= data;
            if (done) begin
                dec_q <= bcd[31:0];
                ovf_q <= |bcd[39:32];
            end
        end
    end

    assign wrap = (pre == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre <= '0;
            idx <= '0;
        end else if (wrap) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_comb begin
        disp     = mod_q ? hex_q : dec_q;
        disp_sh  = disp >> {idx, 2'b00};
        seg_next = glyph(disp_sh[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (!mod_q && (idx != '0) && ((dec_q >> {idx, 2'b00}) == 32'd0))
            seg_next = SEG_BLANK;
`endif
        if (!mod_q && ovf_q)
            seg_next[7] = 1'b0;
    end

    // The outputs load the slot's digit at each wrap, so AN stays blank until the first wrap.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else if (wrap) begin
            an_q  <= ~(8'(1) << idx);
            seg_q <= seg_next;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed cases plus random traffic against a cycle-level model.
module tb_seg_scan;

    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        mod;
    logic [31:0] data;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    int tests = 0;
    int fails = 0;

    seg_scan #(.SCAN_DIV(SCAN_DIV), .DIGITS(8)) dut (
        .clk  (clk),
        .clr  (clr),
        .mod  (mod),
        .data (data),
        .SEG  (SEG),
        .AN   (AN)
    );

    always #5 clk = ~clk;

    logic [7:0] gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          cyc;
    logic        mq;
    int unsigned hexm;
    int unsigned decm;
    logic        ovfm;
    int unsigned pend;
    logic [7:0]  an_exp;
    logic [7:0]  seg_exp;

    function automatic int unsigned pow10(input int k);
        int unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] expect_glyph(input int k);
        int unsigned d;
        logic [7:0]  g;
        d = mq ? ((hexm >> (4 * k)) & 32'hF) : ((decm / pow10(k)) % 10);
        g = gl[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (!mq && k > 0 && decm < pow10(k)) g = 8'hFF;
`endif
        if (!mq && ovfm) g[7] = 1'b0;
        return g;
    endfunction

    // Reference: a slot wraps every SCAN_DIV cycles, conversions repeat every 34 cycles after reset.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            cyc = 0; mq = 1'b1; hexm = 0; decm = 0; ovfm = 1'b0; pend = 0;
            an_exp = 8'hFF; seg_exp = 8'hFF;
        end else begin
            cyc = cyc + 1;
            if (cyc % SCAN_DIV == 0) begin
                an_exp  = ~(8'd1 << (((cyc / SCAN_DIV) - 1) % 8));
                seg_exp = expect_glyph(((cyc / SCAN_DIV) - 1) % 8);
            end
            mq   = mod;
            hexm = data;
            if (cyc % 34 == 1) pend = data;
            if (cyc % 34 == 0) begin
                decm = pend % 100000000;
                ovfm = (pend >= 100000000);
            end
        end
    end

    task automatic checkOutput(input string tag);
        tests++;
        assert (AN === an_exp) else begin
            fails++;
            $error("[TB] FAIL %s AN observed %h expected %h (cyc %0d)", tag, AN, an_exp, cyc);
        end
        tests++;
        assert (SEG === seg_exp) else begin
            fails++;
            $error("[TB] FAIL %s SEG observed %h expected %h (cyc %0d)", tag, SEG, seg_exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [31:0] d, input int n, input string tag);
        mod  = m;
        data = d;
        repeat (n) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin
        clr  = 1'b1;
        mod  = 1'b1;
        data = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset");
        clr = 1'b0;

        applyStimulus(1'b1, 32'h1234ABCD, 20, "hex_scan");
        applyStimulus(1'b0, 32'd12345678, 90, "dec_12345678");
        applyStimulus(1'b0, 32'hFFFFFFFF, 90, "dec_overflow");
        applyStimulus(1'b0, 32'd42, 90, "dec_42");
        applyStimulus(1'b0, 32'd0, 40, "dec_zero");

        for (int i = 0; i < 40 && (cyc % 34) != 0; i++)
            applyStimulus(1'b0, 32'd5, 1, "align");
        applyStimulus(1'b0, 32'd5, 5, "data_5");
        applyStimulus(1'b0, 32'd9, 80, "data_9");

        for (int i = 0; i < 40 && (cyc % 34) != 16; i++)
            applyStimulus(1'b0, 32'd87654321, 1, "pre_clr");
        @(posedge clk);
        #2 clr = 1'b1;
        #1 checkOutput("clr_async");
        @(negedge clk);
        checkOutput("clr_held");
        clr = 1'b0;
        applyStimulus(1'b0, 32'd87654321, 80, "after_clr");

        repeat (30) begin
            logic [31:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 999)) : $urandom();
            applyStimulus(1'($urandom_range(0, 1)), rd, $urandom_range(1, 60), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
